// File: rtl/fifo_stream_packer.sv
// Drains a first-word-fall-through FIFO and emits fixed-length packets on a valid/ready
// stream: one header beat, then PKT_LEN payload beats with m_tlast on the final beat.
module fifo_stream_packer #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned PKT_LEN = 4,
   parameter logic [7:0]  HDR_TAG = 8'hA5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [WIDTH-1:0] m_tdata,
   output logic             m_tlast,
   output logic [15:0]      pkt_count
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SEQ_W = 16;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);
   localparam logic [7:0]       LEN_FIELD = 8'(PKT_LEN);

   typedef struct packed {
      logic [7:0]       tag;
      logic [7:0]       len;
      logic [SEQ_W-1:0] seq;
   } hdr_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
   logic [SEQ_W-1:0] seq, seq_n;
   logic             tvalid_n, tlast_n;
   logic [WIDTH-1:0] tdata_n;
   logic             slot_free;
   hdr_t             hdr;

   // Output stage can take a new beat when empty or when its current beat leaves this cycle.
   assign slot_free = !m_tvalid || m_tready;

   always_comb begin
      hdr     = '0;
      hdr.tag = HDR_TAG;
      hdr.len = LEN_FIELD;
      hdr.seq = seq;
   end

   // Next-state, pop strobe and next output-register values.
   always_comb begin
      state_n    = state;
      beat_cnt_n = beat_cnt;
      seq_n      = seq;
      tvalid_n   = m_tvalid;
      tdata_n    = m_tdata;
      tlast_n    = m_tlast;
      fifo_rd    = 1'b0;

      if (slot_free) begin
         tvalid_n = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (enable && !fifo_empty) begin
               state_n = HEADER;
            end
         end
         HEADER: begin
            if (slot_free) begin
               tdata_n    = WIDTH'(hdr);
               tvalid_n   = 1'b1;
               tlast_n    = 1'b0;
               beat_cnt_n = '0;
               seq_n      = seq + 16'd1;
               state_n    = PAYLOAD;
            end
         end
         PAYLOAD: begin
            // enable is deliberately ignored here: a started packet always completes.
            if (slot_free && !fifo_empty) begin
               fifo_rd  = 1'b1;
               tdata_n  = fifo_data;
               tvalid_n = 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  tlast_n    = 1'b1;
                  beat_cnt_n = '0;
                  state_n    = IDLE;
               end else begin
                  tlast_n    = 1'b0;
                  beat_cnt_n = beat_cnt + 8'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; a reset discards any partial packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         seq      <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else begin
         state    <= state_n;
         beat_cnt <= beat_cnt_n;
         seq      <= seq_n;
         m_tvalid <= tvalid_n;
         m_tdata  <= tdata_n;
         m_tlast  <= tlast_n;
      end
   end

   // Completed packets, counted when the tlast beat is accepted by the sink.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_count <= '0;
      end else if (m_tvalid && m_tready && m_tlast) begin
         pkt_count <= pkt_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Bench for fifo_stream_packer: queue-based FIFO model plus a packet-level scoreboard.
module tb_fifo_stream_packer;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned PKT_LEN = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd;
   logic             m_tvalid;
   logic             m_tready;
   logic [WIDTH-1:0] m_tdata;
   logic             m_tlast;
   logic [15:0]      pkt_count;

   fifo_stream_packer #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .HDR_TAG(8'hA5)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .pkt_count(pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] fifo_q[$];   // words currently in the FIFO
   logic [WIDTH-1:0] ref_q[$];    // words written but not yet seen on the stream
   int          n_cmp = 0;
   int          n_err = 0;
   int          idx = 0;          // position in packet: 0 = header, 1..PKT_LEN = payload
   logic [15:0] seq = 16'd0;
   logic [15:0] exp_pkt = 16'd0;
   int          cyc = 0;
   int          hdr_cyc = 0;
   int          last_cyc = 0;
   int          gap = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] hdr_word(input logic [15:0] s);
      logic [31:0] h;
      h = {8'hA5, 8'(PKT_LEN), s};
      return WIDTH'(h);
   endfunction

   function automatic logic [WIDTH-1:0] exp_next();
      if (idx == 0) return hdr_word(seq);
      if (ref_q.size() == 0) return '0;
      return ref_q[0];
   endfunction

   task automatic push(input logic [WIDTH-1:0] w);
      fifo_q.push_back(w);
      ref_q.push_back(w);
   endtask

   task automatic check_beat(input logic [WIDTH-1:0] d, input logic l);
      if (idx == 0) begin
         chk("hdr_data", 64'(d), 64'(hdr_word(seq)));
         chk("hdr_last", 64'(l), 64'd0);
         gap = cyc - last_cyc;
         hdr_cyc = cyc;
      end else begin
         chk("payload_avail", 64'(ref_q.size() != 0), 64'd1);
         if (ref_q.size() != 0) begin
            chk("payload_data", 64'(d), 64'(ref_q.pop_front()));
            chk("payload_last", 64'(l), 64'(idx == int'(PKT_LEN)));
         end
      end
      idx++;
      if (idx > int'(PKT_LEN)) begin
         idx = 0;
         seq = seq + 16'd1;
         exp_pkt = exp_pkt + 16'd1;
         last_cyc = cyc;
      end
   endtask

   // One clock: present FIFO head, sample handshakes mid-cycle, apply them after the edge.
   task automatic step();
      logic pop, acc, l;
      logic [WIDTH-1:0] d;
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? '0 : fifo_q[0];
      @(negedge clk);
      pop = fifo_rd && !fifo_empty;
      acc = m_tvalid && m_tready;
      d   = m_tdata;
      l   = m_tlast;
      chk("rd_on_empty", 64'(fifo_rd && fifo_empty), 64'd0);
      @(posedge clk);
      #1;
      cyc++;
      if (pop) void'(fifo_q.pop_front());
      if (acc) check_beat(d, l);
      chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
   endtask

   function automatic logic is_idle();
      return (ref_q.size() == 0) && (idx == 0) && !m_tvalid;
   endfunction

   task automatic run_idle(input int budget, input string tag);
      int n = 0;
      while (!is_idle() && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(is_idle()), 64'd1);
   endtask

   task automatic wait_idx(input int target, input int budget, input string tag);
      int n = 0;
      while (idx != target && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(idx), 64'(target));
   endtask

   initial begin
      int pushed;
      int n;
      reset = 1'b0; enable = 1'b0; m_tready = 1'b0;
      fifo_empty = 1'b1; fifo_data = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      step(); step();
      reset = 1'b0;

      // Empty FIFO with enable high: nothing happens.
      enable = 1'b1; m_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("empty_tvalid", 64'(m_tvalid), 64'd0);
         chk("empty_rd", 64'(fifo_rd), 64'd0);
      end

      // First packet 1..4, full-rate sink.
      for (int i = 1; i <= 4; i++) push(WIDTH'(i));
      run_idle(40, "pkt1_done");
      chk("pkt1_burst", 64'(last_cyc - hdr_cyc), 64'd4);
      chk("pkt1_count", 64'(pkt_count), 64'd1);

      // Two back-to-back packets: one idle cycle, then the header.
      for (int i = 5; i <= 12; i++) push(WIDTH'(i));
      run_idle(60, "pkt23_done");
      chk("b2b_gap", 64'(gap), 64'd2);
      chk("pkt23_count", 64'(pkt_count), 64'd3);

      // Sink backpressure mid-payload.
      for (int i = 0; i < 4; i++) push(WIDTH'($urandom()));
      wait_idx(2, 40, "bp_reach");
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_tvalid", 64'(m_tvalid), 64'd1);
         chk("stall_rd", 64'(fifo_rd), 64'd0);
         chk("stall_tdata", 64'(m_tdata), 64'(exp_next()));
      end
      m_tready = 1'b1;
      run_idle(40, "bp_done");
      chk("bp_count", 64'(pkt_count), 64'd4);

      // FIFO runs dry after two payload beats; enable dropped before it refills.
      push(32'h0000_0021); push(32'h0000_0022);
      n = 0;
      while (ref_q.size() != 0 && n < 40) begin step(); n++; end
      chk("dry_reach", 64'(ref_q.size()), 64'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("dry_tvalid", 64'(m_tvalid), 64'd0);
         chk("dry_rd", 64'(fifo_rd), 64'd0);
      end
      enable = 1'b0;
      push(32'h0000_0023); push(32'h0000_0024);
      run_idle(40, "dry_done");
      chk("dry_count", 64'(pkt_count), 64'd5);
      for (int i = 0; i < 4; i++) push(WIDTH'($urandom()));
      for (int i = 0; i < 10; i++) begin
         step();
         chk("noen_tvalid", 64'(m_tvalid), 64'd0);
         chk("noen_rd", 64'(fifo_rd), 64'd0);
      end
      enable = 1'b1;
      run_idle(40, "noen_done");
      chk("noen_count", 64'(pkt_count), 64'd6);

      // Asynchronous reset in the middle of a payload.
      for (int i = 0; i < 4; i++) push(WIDTH'($urandom()));
      wait_idx(2, 40, "mid_reach");
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
      chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
      chk("mid_rst_count", 64'(pkt_count), 64'd0);
      chk("mid_rst_rd", 64'(fifo_rd), 64'd0);
      fifo_q.delete(); ref_q.delete();
      idx = 0; seq = 16'd0; exp_pkt = 16'd0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) push(WIDTH'($urandom()));
      run_idle(40, "post_rst_done");
      chk("post_rst_count", 64'(pkt_count), 64'd1);

      // Random traffic: 500 words, random sink stalls and enable gaps.
      pushed = 0; n = 0;
      while ((pushed < 500 || !is_idle()) && n < 20000) begin
         if (pushed < 500) begin
            int k;
            k = int'($urandom_range(0, 2));
            for (int j = 0; j < k && pushed < 500; j++) begin
               push(WIDTH'($urandom()));
               pushed++;
            end
         end
         m_tready = ($urandom_range(0, 3) != 0);
         enable   = (pushed >= 500) || ($urandom_range(0, 7) != 0);
         step();
         n++;
      end
      chk("rand_drain", 64'(is_idle()), 64'd1);
      chk("rand_count", 64'(pkt_count), 64'd126);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
